// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing A - B - B_IN,
// LSB first, through one full-subtractor cell and a borrow flop.
// Operands are captured on an accepted START; D/B_OUT (and OVF) are updated
// together with a one-cycle DONE pulse.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the OVF port, which flags
// a result that does not fit in signed WIDTH bits.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             B_OUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic diff_bit_s;
  logic bnext_s;

  // Full-subtractor cell working on the current LSBs and the stored borrow.
  always_comb begin
    diff_bit_s = a_q[0] ^ b_q[0] ^ borrow_q;
    bnext_s    = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
  end

  // Next-state and datapath control: load on accepted START, shift during RUN,
  // publish the full result only on the last bit.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d  = S_RUN;
          a_d      = A;
          b_d      = B;
          borrow_d = B_IN;
          res_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        res_d    = {diff_bit_s, res_q[WIDTH-1:1]};
        borrow_d = bnext_s;
        if (cnt_q == LAST_BIT) begin
          // borrow_q here is the borrow into the MSB, bnext_s the one out of it.
          state_d = S_DONE;
          d_d     = {diff_bit_s, res_q[WIDTH-1:1]};
          bout_d  = bnext_s;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = borrow_q ^ bnext_s;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign D     = d_q;
  assign B_OUT = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): hand vectors, a full
// operand sweep against an arithmetic model, held-START and mid-op reset.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         B_IN;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         B_OUT;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .B_IN  (B_IN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
    .B_OUT (B_OUT)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and signed arithmetic on plain integers.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int ua;
    int ub;
    int r;
    int sa;
    int sb;
    int sr;
    ua = int'(a);
    ub = int'(b);
    r  = ua - ub - int'(bin);
    bo = (r < 0);
    d  = W'(r & 15);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sr = sa - sb - int'(bin);
    ov = (sr < -8) || (sr > 7);
  endfunction

  // One full operation: accept START, wait (bounded) for DONE, check latency,
  // result and the single-cycle pulse.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] ed, input logic ebo, input logic eov);
    int lat;
    lat = 0;
    @(negedge CLK);
    A = a; B = b; B_IN = bin; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; A = ~a; B = ~b; B_IN = ~bin;
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      chk({tag, "_excl"}, {31'd0, BUSY & DONE}, 32'd0);
      if (DONE) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_d"}, {28'd0, D}, {28'd0, ed});
    chk({tag, "_bout"}, {31'd0, B_OUT}, {31'd0, ebo});
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, OVF}, {31'd0, eov});
`else
    if (eov === 1'bx) $display("unexpected x in ovf argument");
`endif
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_hold"}, {27'd0, B_OUT, D}, {27'd0, ebo, ed});
  endtask

  initial begin
    logic [W-1:0] md;
    logic         mbo;
    logic         mov;
    int           quiet;

    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; B_IN = 1'b0;
    #12;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_d", {28'd0, D}, 32'd0);
    chk("rst_bout", {31'd0, B_OUT}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, OVF}, 32'd0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vectors, expected values worked by hand.
    // 9-3: borrow enters MSB but not out of it, so signed overflow (-7-3).
    run_op("basic", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    run_op("under", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    run_op("negov", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    run_op("bin",   4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    run_op("equal", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    run_op("max",   4'hF, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0);

    // Full sweep against the model.
    for (int i = 0; i < 512; i++) begin
      model(W'(i & 15), W'((i >> 4) & 15), 1'((i >> 8) & 1), md, mbo, mov);
      run_op("sweep", W'(i & 15), W'((i >> 4) & 15), 1'((i >> 8) & 1), md, mbo, mov);
    end

    // START held high through RUN with toggling operands; START in DONE
    // cycle launches the next operation immediately.
    @(negedge CLK);
    A = 4'd5; B = 4'd2; B_IN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    for (int k = 1; k <= W; k++) begin
      @(negedge CLK);
      A = 4'($urandom_range(15)); B = 4'($urandom_range(15)); B_IN = 1'($urandom_range(1));
      @(posedge CLK); #1;
      if (k < W) chk("held_nodone", {31'd0, DONE}, 32'd0);
    end
    chk("held_done", {31'd0, DONE}, 32'd1);
    chk("held_d", {28'd0, D}, 32'd3);
    chk("held_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    A = 4'd12; B = 4'd4; B_IN = 1'b0;
    @(posedge CLK); #1;
    chk("b2b_busy", {31'd0, BUSY}, 32'd1);
    chk("b2b_done", {31'd0, DONE}, 32'd0);
    START = 1'b0; A = 4'd1; B = 4'd7;
    for (int k = 1; k < W; k++) begin
      @(posedge CLK); #1;
      chk("b2b_nodone", {31'd0, DONE}, 32'd0);
    end
    @(posedge CLK); #1;
    chk("b2b_done2", {31'd0, DONE}, 32'd1);
    chk("b2b_d", {28'd0, D}, 32'd8);
    @(posedge CLK); #1;
    chk("b2b_single", {31'd0, DONE}, 32'd0);

    // Reset two cycles into an operation, previous D = 6.
    run_op("pre_rst", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    @(negedge CLK);
    A = 4'd2; B = 4'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, BUSY}, 32'd0);
    chk("mrst_d", {28'd0, D}, 32'd0);
    chk("mrst_bout", {31'd0, B_OUT}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    quiet = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(posedge CLK); #1;
      quiet = quiet + int'(DONE) + int'(BUSY);
    end
    chk("mrst_quiet", quiet, 0);
    run_op("post_rst", 4'd7, 4'd2, 1'b1, 4'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
